// File: rtl/mgc_out_fifo_wait_edge_core_pkg.sv
// Shared constants and helpers for the edge-detect output FIFO.
// Pointer wrap and occupancy width live here so top and bench agree.
package mgc_out_fifo_wait_edge_core_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_FIFO_SZ = 8;
    localparam int DEF_PH_LOG2 = 3;

    // Occupancy needs one extra bit to hold the full value.
    function automatic int occ_width(input int ph_log2);
        return ph_log2 + 1;
    endfunction

    // Advance a pointer, wrapping after depth-1 (depth need not be 2^n).
    function automatic int unsigned next_ptr(
        input int unsigned ptr,
        input int unsigned depth
    );
        return (ptr + 1 >= depth) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/mgc_out_fifo_wait_edge_core_edge_fifo_ram.sv
// Register-array storage for the output FIFO.
// Synchronous write, asynchronous (show-ahead) read; contents never reset.
module edge_fifo_ram #(
    parameter int width = 8,
    parameter int depth = 8,
    parameter int aw    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [aw-1:0]    waddr,
    input  logic [width-1:0] wdata,
    input  logic [aw-1:0]    raddr,
    output logic [width-1:0] rdata
);

    logic [width-1:0] mem_q [0:depth-1];

    // Store the incoming word on a qualified write strobe.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mgc_out_fifo_wait_edge_core.sv
// Output-side show-ahead FIFO between the design core and the wait channel.
// fifo_sz=0 collapses to a purely combinational pass-through.
module mgc_out_fifo_wait_edge_core
    import mgc_out_fifo_wait_edge_core_pkg::*;
#(
    parameter int rscid   = 0,
    parameter int width   = DEF_WIDTH,
    parameter int fifo_sz = DEF_FIFO_SZ,
    parameter int ph_log2 = DEF_PH_LOG2
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               en,
    input  logic               ld,
    output logic               vd,
    input  logic [width-1:0]   d,
    output logic               lz,
    input  logic               vz,
    output logic [width-1:0]   z,
    output logic [ph_log2:0]   size
);

    localparam int unused_rscid = rscid;

    generate
        if (fifo_sz == 0) begin : g_pass

            logic unused_pass;
            assign unused_pass = ^{clk, arst, en};

            assign z    = d;
            assign lz   = ld;
            assign vd   = vz;
            assign size = '0;

        end else begin : g_fifo

            localparam int CW = occ_width(ph_log2);

            typedef logic [ph_log2-1:0] ptr_t;
            typedef logic [CW-1:0]      cnt_t;

            localparam cnt_t FULL = cnt_t'(fifo_sz);
            localparam cnt_t ONE  = cnt_t'(1);

            ptr_t wr_ptr_q, wr_ptr_d;
            ptr_t rd_ptr_q, rd_ptr_d;
            cnt_t count_q, count_d;
            logic wr_en, rd_en;
            logic [width-1:0] rdata;

            // Qualify handshakes from held state and compute next pointers/count.
            always_comb begin
                wr_en    = en && ld && (count_q != FULL);
                rd_en    = en && vz && (count_q != '0);
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                if (wr_en) begin
                    wr_ptr_d = ptr_t'(next_ptr(32'(wr_ptr_q), fifo_sz));
                end
                if (rd_en) begin
                    rd_ptr_d = ptr_t'(next_ptr(32'(rd_ptr_q), fifo_sz));
                end
                if (wr_en && !rd_en) begin
                    count_d = count_q + ONE;
                end else if (!wr_en && rd_en) begin
                    count_d = count_q - ONE;
                end
            end

            // Pointer and occupancy registers; reset empties the FIFO at once.
            always_ff @(posedge clk or posedge arst) begin
                if (arst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
            end

            edge_fifo_ram #(
                .width (width),
                .depth (fifo_sz),
                .aw    (ph_log2)
            ) u_ram (
                .clk   (clk),
                .we    (wr_en),
                .waddr (wr_ptr_q),
                .wdata (d),
                .raddr (rd_ptr_q),
                .rdata (rdata)
            );

            assign vd   = (count_q != FULL);
            assign lz   = (count_q != '0);
            assign z    = lz ? rdata : '0;
            assign size = count_q;

        end
    endgenerate

endmodule

// File: tb/tb_mgc_out_fifo_wait_edge_core.sv
// Directed bench for the output FIFO: depth 4, depth 3 and pass-through.
// Inputs change 1 time unit after the rising edge; outputs checked there.
module tb_mgc_out_fifo_wait_edge_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic       arst4, en4, ld4, vz4, vd4, lz4;
    logic [7:0] d4, z4;
    logic [2:0] size4;

    logic       arst3, en3, ld3, vz3, vd3, lz3;
    logic [7:0] d3, z3;
    logic [2:0] size3;

    logic       arst_p, en_p, ld_p, vz_p, vd_p, lz_p;
    logic [7:0] d_p, z_p;
    logic [3:0] size_p;

    mgc_out_fifo_wait_edge_core #(
        .rscid(1), .width(8), .fifo_sz(4), .ph_log2(2)
    ) dut4 (
        .clk(clk), .arst(arst4), .en(en4), .ld(ld4), .vd(vd4), .d(d4),
        .lz(lz4), .vz(vz4), .z(z4), .size(size4)
    );

    mgc_out_fifo_wait_edge_core #(
        .rscid(2), .width(8), .fifo_sz(3), .ph_log2(2)
    ) dut3 (
        .clk(clk), .arst(arst3), .en(en3), .ld(ld3), .vd(vd3), .d(d3),
        .lz(lz3), .vz(vz3), .z(z3), .size(size3)
    );

    mgc_out_fifo_wait_edge_core #(
        .rscid(3), .width(8), .fifo_sz(0), .ph_log2(3)
    ) dutp (
        .clk(clk), .arst(arst_p), .en(en_p), .ld(ld_p), .vd(vd_p), .d(d_p),
        .lz(lz_p), .vz(vz_p), .z(z_p), .size(size_p)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ld4 = 1'b1; d4 = 8'h99;
        cyc();
        ld4 = 1'b0;
        checks++;
        if (size4 !== 3'd1) begin
            failures++;
            $display("FAIL rst_pre_size got=%0d exp=1", size4);
        end
        #2 arst4 = 1'b1;
        #1;
        checks++;
        if (vd4 !== 1'b1) begin
            failures++;
            $display("FAIL rst_vd got=%b exp=1", vd4);
        end
        checks++;
        if (lz4 !== 1'b0) begin
            failures++;
            $display("FAIL rst_lz got=%b exp=0", lz4);
        end
        checks++;
        if (z4 !== 8'h00) begin
            failures++;
            $display("FAIL rst_z got=%h exp=00", z4);
        end
        checks++;
        if (size4 !== 3'd0) begin
            failures++;
            $display("FAIL rst_size got=%0d exp=0", size4);
        end
        #1 arst4 = 1'b0;
        cyc();
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp [4];
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        ld4 = 1'b1; vz4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d4 = exp[i];
            cyc();
        end
        checks++;
        if (size4 !== 3'd4) begin
            failures++;
            $display("FAIL fill_size got=%0d exp=4", size4);
        end
        checks++;
        if (vd4 !== 1'b0) begin
            failures++;
            $display("FAIL fill_vd got=%b exp=0", vd4);
        end
        d4 = 8'h55;
        cyc();
        checks++;
        if (size4 !== 3'd4 || z4 !== 8'h11) begin
            failures++;
            $display("FAIL full_ignore got size=%0d z=%h exp size=4 z=11",
                     size4, z4);
        end
        ld4 = 1'b0; vz4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (lz4 !== 1'b1 || z4 !== exp[i]) begin
                failures++;
                $display("FAIL drain_%0d got lz=%b z=%h exp lz=1 z=%h",
                         i, lz4, z4, exp[i]);
            end
            cyc();
        end
        vz4 = 1'b0;
        checks++;
        if (lz4 !== 1'b0 || size4 !== 3'd0 || z4 !== 8'h00) begin
            failures++;
            $display("FAIL drain_empty got lz=%b size=%0d z=%h exp 0/0/00",
                     lz4, size4, z4);
        end
        vz4 = 1'b1;
        cyc();
        vz4 = 1'b0;
        checks++;
        if (size4 !== 3'd0 || vd4 !== 1'b1) begin
            failures++;
            $display("FAIL underflow got size=%0d vd=%b exp 0/1", size4, vd4);
        end
    endtask

    task automatic test_simul_rw();
        logic [7:0] exp [3];
        exp = '{8'h22, 8'h33, 8'h44};
        ld4 = 1'b1; vz4 = 1'b0;
        d4 = 8'h11; cyc();
        d4 = 8'h22; cyc();
        d4 = 8'h33; cyc();
        d4 = 8'h44; cyc();
        d4 = 8'h66; vz4 = 1'b1;
        cyc();
        ld4 = 1'b0;
        checks++;
        if (size4 !== 3'd3 || z4 !== 8'h22) begin
            failures++;
            $display("FAIL simul_full got size=%0d z=%h exp size=3 z=22",
                     size4, z4);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (z4 !== exp[i]) begin
                failures++;
                $display("FAIL simul_drain_%0d got=%h exp=%h", i, z4, exp[i]);
            end
            cyc();
        end
        vz4 = 1'b0;
        checks++;
        if (lz4 !== 1'b0) begin
            failures++;
            $display("FAIL simul_empty got lz=%b exp=0", lz4);
        end
        ld4 = 1'b1; vz4 = 1'b1; d4 = 8'hAA;
        cyc();
        ld4 = 1'b0; vz4 = 1'b0;
        checks++;
        if (size4 !== 3'd1 || z4 !== 8'hAA) begin
            failures++;
            $display("FAIL simul_empty_rw got size=%0d z=%h exp 1/aa",
                     size4, z4);
        end
        ld4 = 1'b1; d4 = 8'hBB;
        cyc();
        d4 = 8'hCC; vz4 = 1'b1;
        cyc();
        ld4 = 1'b0;
        checks++;
        if (size4 !== 3'd2 || z4 !== 8'hBB) begin
            failures++;
            $display("FAIL simul_mid got size=%0d z=%h exp size=2 z=bb",
                     size4, z4);
        end
        cyc();
        checks++;
        if (z4 !== 8'hCC) begin
            failures++;
            $display("FAIL simul_mid_tail got=%h exp=cc", z4);
        end
        cyc();
        vz4 = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] q [$];
        int cnt = 0;
        int sent = 0;
        int rcvd = 0;
        int n = 0;
        logic wr, rd;
        vz3 = 1'b0;
        while (rcvd < 10 && n < 60) begin
            ld3 = (sent < 10);
            d3  = 8'(sent + 1);
            checks++;
            if (size3 !== 3'(cnt) || size3 > 3'd3) begin
                failures++;
                $display("FAIL wrap_size cyc=%0d got=%0d exp=%0d", n, size3, cnt);
            end
            if (cnt > 0) begin
                checks++;
                if (lz3 !== 1'b1 || z3 !== q[0]) begin
                    failures++;
                    $display("FAIL wrap_data cyc=%0d got=%h exp=%h", n, z3, q[0]);
                end
            end
            wr = ld3 && (cnt < 3);
            rd = vz3 && (cnt > 0);
            if (rd) begin
                void'(q.pop_front());
                rcvd++;
                cnt--;
            end
            if (wr) begin
                q.push_back(d3);
                sent++;
                cnt++;
            end
            cyc();
            vz3 = ~vz3;
            n++;
        end
        ld3 = 1'b0; vz3 = 1'b0;
        checks++;
        if (rcvd != 10 || lz3 !== 1'b0) begin
            failures++;
            $display("FAIL wrap_done got rcvd=%0d lz=%b exp 10/0", rcvd, lz3);
        end
    endtask

    task automatic test_en_arst();
        ld4 = 1'b1; vz4 = 1'b0;
        d4 = 8'h31; cyc();
        d4 = 8'h32; cyc();
        en4 = 1'b0; vz4 = 1'b1; d4 = 8'h77;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (size4 !== 3'd2 || z4 !== 8'h31 || vd4 !== 1'b1) begin
                failures++;
                $display("FAIL en_hold_%0d got size=%0d z=%h vd=%b exp 2/31/1",
                         i, size4, z4, vd4);
            end
        end
        en4 = 1'b1; ld4 = 1'b0; vz4 = 1'b0;
        #2 arst4 = 1'b1;
        #2 arst4 = 1'b0;
        checks++;
        if (size4 !== 3'd0 || lz4 !== 1'b0) begin
            failures++;
            $display("FAIL arst_mid got size=%0d lz=%b exp 0/0", size4, lz4);
        end
        cyc();
        ld4 = 1'b1; d4 = 8'h5A;
        #1;
        checks++;
        if (lz4 !== 1'b0 || z4 !== 8'h00) begin
            failures++;
            $display("FAIL no_bypass got lz=%b z=%h exp 0/00", lz4, z4);
        end
        cyc();
        ld4 = 1'b0;
        checks++;
        if (lz4 !== 1'b1 || z4 !== 8'h5A || size4 !== 3'd1) begin
            failures++;
            $display("FAIL post_arst_wr got lz=%b z=%h size=%0d exp 1/5a/1",
                     lz4, z4, size4);
        end
    endtask

    task automatic test_passthru();
        d_p = 8'hA5; ld_p = 1'b1; vz_p = 1'b0;
        #1;
        checks++;
        if (z_p !== 8'hA5 || lz_p !== 1'b1 || vd_p !== 1'b0 || size_p !== 4'd0) begin
            failures++;
            $display("FAIL pass_a got z=%h lz=%b vd=%b size=%0d exp a5/1/0/0",
                     z_p, lz_p, vd_p, size_p);
        end
        d_p = 8'h3C; ld_p = 1'b0; vz_p = 1'b1;
        #1;
        checks++;
        if (z_p !== 8'h3C || lz_p !== 1'b0 || vd_p !== 1'b1) begin
            failures++;
            $display("FAIL pass_b got z=%h lz=%b vd=%b exp 3c/0/1",
                     z_p, lz_p, vd_p);
        end
    endtask

    initial begin
        arst4 = 1'b1; en4 = 1'b1; ld4 = 1'b0; vz4 = 1'b0; d4 = 8'h00;
        arst3 = 1'b1; en3 = 1'b1; ld3 = 1'b0; vz3 = 1'b0; d3 = 8'h00;
        arst_p = 1'b0; en_p = 1'b0; ld_p = 1'b0; vz_p = 1'b0; d_p = 8'h00;
        cyc();
        cyc();
        arst4 = 1'b0;
        arst3 = 1'b0;
        cyc();
        test_reset();
        test_fill_drain();
        test_simul_rw();
        test_wrap();
        test_en_arst();
        test_passthru();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
